// File: rtl/rpn_stack_sequencer_pkg.sv
// rpn_pkg: shared definitions for the RPN stack sequencer.
//   - rpn_op_e     : 3-bit command opcodes (encoding 7 is undefined)
//   - ERR_*        : completion status codes reported with done
//   - rpn_state_e  : sequencer FSM states
//   - RPN_W/RPN_DEPTH : default data width and stack capacity
//   - is_binary()  : true for the two-operand opcodes that are always present
package rpn_pkg;

  localparam int RPN_W     = 16;
  localparam int RPN_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_MUL  = 3'd6
  } rpn_op_e;

  localparam logic [1:0] ERR_OK        = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP1,
    S_POP2,
    S_PUSH,
    S_DONE
  } rpn_state_e;

  // MUL is excluded here because its availability depends on the build.
  function automatic logic is_binary(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/rpn_stack_sequencer_if.sv
// rpn_stack_sequencer_if: command and stack-side signals of the sequencer.
//   Command side : cmd_valid, cmd_op, cmd_val (requester -> sequencer),
//                  cmd_ready, done, err (sequencer -> requester)
//   Stack side   : stk_push, stk_pop, stk_val (sequencer -> stack),
//                  stk_top, stk_next, stk_count (stack -> sequencer)
//   Modports     : slave  = the sequencer
//                  master = the surrounding system (requester + stack)
interface rpn_stack_sequencer_if
  import rpn_pkg::*;
#(
  parameter int W = RPN_W
);

  logic         cmd_valid;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_val;
  logic         cmd_ready;
  logic         stk_push;
  logic         stk_pop;
  logic [W-1:0] stk_val;
  logic [W-1:0] stk_top;
  logic [W-1:0] stk_next;
  logic [7:0]   stk_count;
  logic         done;
  logic [1:0]   err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_val, stk_top, stk_next, stk_count,
    output cmd_ready, stk_push, stk_pop, stk_val, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_val, stk_top, stk_next, stk_count,
    input  cmd_ready, stk_push, stk_pop, stk_val, done, err
  );

endinterface

// File: rtl/rpn_stack_sequencer_alu.sv
// rpn_alu: combinational result of one RPN operation, modulo 2^W.
//   a_i      : second stack entry (next)
//   b_i      : top stack entry, or the PUSH operand
//   op_i     : opcode
//   result_o : ADD a+b, SUB a-b, AND/OR bitwise, MUL low W bits of a*b
//              (only when RPN_SEQ_MUL_EN is defined); anything else passes b
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int W = RPN_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  rpn_op_e      op_i,
  output logic [W-1:0] result_o
);

  always_comb begin
    result_o = b_i;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
`ifdef RPN_SEQ_MUL_EN
      OP_MUL:  result_o = a_i * b_i;
`endif
      default: result_o = b_i;
    endcase
  end

endmodule

// File: rtl/rpn_stack_sequencer.sv
// rpn_stack_sequencer: turns one RPN command at a time into pop/push strobes
// for an external stack and reports completion with done/err.
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : rpn_stack_sequencer_if.slave (command handshake, stack strobes,
//          stack observation, done/err status)
// Build option: define RPN_SEQ_MUL_EN to enable the MUL opcode; otherwise
// MUL is reported as illegal.
module rpn_stack_sequencer
  import rpn_pkg::*;
#(
  parameter int W     = RPN_W,
  parameter int DEPTH = RPN_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  rpn_stack_sequencer_if.slave         bus
);

`ifdef RPN_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [7:0] DEPTH_C = 8'(DEPTH);

  rpn_state_e   state_q, state_d;
  rpn_op_e      op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [1:0]   err_q, err_d;
  logic         accept;
  logic [W-1:0] alu_res;

  // Status is decided entirely from the occupancy seen at acceptance, so a
  // failing command never touches the stack.
  function automatic logic [1:0] cmd_err(input logic [2:0] op, input logic [7:0] cnt);
    if (op == OP_PUSH) return (cnt >= DEPTH_C) ? ERR_OVERFLOW : ERR_OK;
    if (op == OP_POP)  return (cnt == 8'd0) ? ERR_UNDERFLOW : ERR_OK;
    if (is_binary(op) || (MUL_EN && (op == OP_MUL)))
      return (cnt < 8'd2) ? ERR_UNDERFLOW : ERR_OK;
    return ERR_ILLEGAL;
  endfunction

  assign accept = bus.cmd_valid && (state_q == S_IDLE);

  // Operands are captured before the pops change the stack outputs. For PUSH
  // the operand rides in b_q and the ALU passes it through unchanged.
  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    err_d = err_q;
    if (accept) begin
      op_d  = rpn_op_e'(bus.cmd_op);
      a_d   = bus.stk_next;
      b_d   = bus.stk_top;
      err_d = cmd_err(bus.cmd_op, bus.stk_count);
      if (bus.cmd_op == OP_PUSH) begin
        a_d = '0;
        b_d = bus.cmd_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_PUSH;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (err_d != ERR_OK)      state_d = S_DONE;
          else if (op_d == OP_PUSH) state_d = S_PUSH;
          else                      state_d = S_POP1;
        end
      end
      S_POP1:  state_d = (op_q == OP_POP) ? S_DONE : S_POP2;
      S_POP2:  state_d = S_PUSH;
      S_PUSH:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  rpn_alu #(.W(W)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_res)
  );

  // Strobes are pure functions of the state, so push and pop are mutually
  // exclusive and everything drops to zero as soon as reset forces IDLE.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.stk_push  = 1'b0;
    bus.stk_pop   = 1'b0;
    bus.stk_val   = '0;
    bus.done      = 1'b0;
    bus.err       = ERR_OK;
    case (state_q)
      S_IDLE: bus.cmd_ready = 1'b1;
      S_POP1,
      S_POP2: bus.stk_pop = 1'b1;
      S_PUSH: begin
        bus.stk_push = 1'b1;
        bus.stk_val  = alu_res;
      end
      S_DONE: begin
        bus.done = 1'b1;
        bus.err  = err_q;
      end
      default: ;
    endcase
  end

endmodule
